// File: rtl/bot_feeder_pkg.sv
// ------------------------------------------------------------------
// bot_feeder_pkg: feeder state encoding, bot width, FIFO sizing helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package bot_feeder_pkg;

  localparam int BOT_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAMING = 2'd1,
    ST_DRAINING  = 2'd2
  } feeder_state_t;

  function automatic int fifo_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bot_fifo_fwft.sv
// ------------------------------------------------------------------
// bot_fifo_fwft: first-word-fall-through FIFO with a registered head
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bot_fifo_fwft import bot_feeder_pkg::*; #(
  parameter int WIDTH = 142,
  parameter int DEPTH = 16,
  localparam int AW   = fifo_addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic             do_push;
  logic             do_pop;

  assign full       = (level == FULL_LEVEL);
  assign empty      = (level == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Head tracks mem[rd_ptr]; an incoming word lands in it only when it becomes the new head.
      if (do_push && (empty || (do_pop && level == ONE_LEVEL))) begin
        head <= din;
      end else if (do_pop && level > ONE_LEVEL) begin
        head <= mem[rd_ptr_inc];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bot_feeder.sv
// ------------------------------------------------------------------
// bot_feeder: buffers tagged bots for the compute module, tracks batch drain
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bot_feeder import bot_feeder_pkg::*; #(
  parameter int EXTRA_DATA_WIDTH  = 14,
  parameter int FIFO_DEPTH        = 16,
  parameter int OUTSTANDING_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         botValid,
  input  logic [BOT_WIDTH-1:0]         botData,
  input  logic                         botLast,
  output logic                         botReady,
  input  logic                         requestGraph,
  output logic [BOT_WIDTH-1:0]         botOut,
  output logic                         graphAvailable,
  output logic [EXTRA_DATA_WIDTH-1:0]  extraDataOut,
  input  logic                         resultDone,
  output logic [OUTSTANDING_WIDTH-1:0] outstanding,
  output logic                         batchDone,
  output logic                         protocolError
);

  localparam int AW    = fifo_addr_width(FIFO_DEPTH);
  localparam int WIDTH = BOT_WIDTH + EXTRA_DATA_WIDTH;
  localparam logic [AW:0] ONE_LEVEL = (AW+1)'(1);

  feeder_state_t                state;
  feeder_state_t                state_next;
  logic [EXTRA_DATA_WIDTH-1:0]  tag;
  logic [OUTSTANDING_WIDTH-1:0] outstanding_next;
  logic                         error_next;
  logic                         done_next;
  logic                         empty_next;
  logic                         push;
  logic                         issue;
  logic                         full;
  logic                         empty;
  logic [AW:0]                  level;
  logic [WIDTH-1:0]             head;

  assign botReady       = ~full & (state != ST_DRAINING);
  assign push           = botValid & botReady;
  assign graphAvailable = ~empty;
  assign issue          = requestGraph & ~empty;
  assign botOut         = head[WIDTH-1:EXTRA_DATA_WIDTH];
  assign extraDataOut   = head[EXTRA_DATA_WIDTH-1:0];
  assign empty_next     = ~push & (empty | (issue & (level == ONE_LEVEL)));

  bot_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({botData, tag}),
    .pop   (issue),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    outstanding_next = outstanding;
    error_next       = protocolError;
    if (issue && !resultDone) begin
      if (&outstanding) error_next = 1'b1;
      else              outstanding_next = outstanding + 1'b1;
    end else if (resultDone && !issue) begin
      if (outstanding == '0) error_next = 1'b1;
      else                   outstanding_next = outstanding - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (push) state_next = botLast ? ST_DRAINING : ST_STREAMING;
      end
      ST_STREAMING: begin
        if (push && botLast) state_next = ST_DRAINING;
      end
      ST_DRAINING: begin
        // Completion looks at post-edge occupancy so a final same-cycle issue/return counts.
        if (empty_next && outstanding_next == '0) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      tag           <= '0;
      outstanding   <= '0;
      batchDone     <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      state         <= state_next;
      outstanding   <= outstanding_next;
      batchDone     <= done_next;
      protocolError <= error_next;
      if (done_next)  tag <= '0;
      else if (push)  tag <= tag + 1'b1;
    end
  end

endmodule

`default_nettype wire
